// File: rtl/des_initial_permutation_loader.sv
// Byte-serial DES input stage: assembles eight bytes into a 64-bit block, applies the
// Initial Permutation and holds L0/R0 in a registered output slot behind a valid/ready handshake.
module des_initial_permutation_loader #(
  parameter bit BYPASS_IP = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_abort,
  output logic [31:0] o_left,
  output logic [31:0] o_right,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [2:0]  o_count
);

  // Bytes 0..6 only; the eighth byte goes straight into the output slot.
  logic [55:0] asm_q;
  logic [2:0]  count_q;
  logic [63:0] block_full;
  logic [63:0] perm;
  logic        accept;
  logic        load;
  logic        drain;

  // Bit 0 of the bus is DES bit 1, so each byte lands MSB-first at the low index.
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = b[7-j];
    return r;
  endfunction

  function automatic logic [63:0] ip_perm(input logic [63:0] blk);
    logic [63:0] p;
    int          base;
    p = '0;
    for (int r = 0; r < 8; r++) begin
      base = (r < 4) ? (57 + 2 * r) : (56 + 2 * (r - 4));
      for (int c = 0; c < 8; c++) p[8*r+c] = blk[base-8*c];
    end
    return p;
  endfunction

  // NOTE: combinational outputs are plain continuous assigns; nothing here can infer a latch.
  assign o_byte_ready = !i_abort && !(count_q == 3'd7 && o_valid && !i_ready);
  assign accept       = i_byte_valid && o_byte_ready;
  assign load         = accept && (count_q == 3'd7);
  assign drain        = o_valid && i_ready;
  assign block_full   = {rev8(i_byte), asm_q};
  assign o_count      = count_q;

  if (BYPASS_IP) begin : g_bypass
    assign perm = block_full;
  end else begin : g_ip
    assign perm = ip_perm(block_full);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      asm_q   <= '0;
      count_q <= '0;
      o_left  <= '0;
      o_right <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_abort) begin
        asm_q   <= '0;
        count_q <= '0;
      end else if (accept) begin
        if (count_q == 3'd7) begin
          count_q <= '0;
        end else begin
          count_q <= count_q + 3'd1;
          for (int n = 0; n < 7; n++)
            if (count_q == 3'(n)) asm_q[8*n +: 8] <= rev8(i_byte);
        end
      end

      // A load is only possible into an empty or draining slot, which the ready gate guarantees.
      if (load) begin
        o_left  <= perm[31:0];
        o_right <= perm[63:32];
        o_valid <= 1'b1;
      end else if (drain) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_des_initial_permutation_loader.sv
// Bench for des_initial_permutation_loader: known-answer table, back-pressure, abort, reset
// and random round trip through the standard DES FP, against a DES-notation reference model.
module tb_des_initial_permutation_loader;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        i_abort;
  logic        i_ready;
  logic        o_byte_ready, o_valid;
  logic [31:0] o_left, o_right;
  logic [2:0]  o_count;
  logic        b_byte_ready, b_valid;
  logic [31:0] b_left, b_right;
  logic [2:0]  b_count;

  always #5 clk = ~clk;

  des_initial_permutation_loader #(.BYPASS_IP(1'b0)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready), .i_abort(i_abort), .o_left(o_left), .o_right(o_right),
    .o_valid(o_valid), .i_ready(i_ready), .o_count(o_count)
  );

  des_initial_permutation_loader #(.BYPASS_IP(1'b1)) dut_bypass (
    .i_clk(clk), .i_rst(i_rst), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
    .o_byte_ready(b_byte_ready), .i_abort(i_abort), .o_left(b_left), .o_right(b_right),
    .o_valid(b_valid), .i_ready(i_ready), .o_count(b_count)
  );

  int total = 0;
  int bad   = 0;

  int ip_tab[64];
  int fp_tab[64];

  // Reference model, in DES notation (bit 1 = MSB of a 64-bit value).
  int          m_count;
  logic [63:0] m_asm;
  logic        m_valid;
  logic [63:0] m_block;
  logic        last_acc;
  int          drained;

  typedef struct {
    logic [63:0] din;
    logic [31:0] l0;
    logic [31:0] r0;
  } kat_t;
  kat_t kat[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  function automatic logic [63:0] rev64(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[i] = x[63-i];
    return y;
  endfunction

  // DES bit k lives at x[64-k].
  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-ip_tab[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-fp_tab[i]];
    return y;
  endfunction

  // One clock: check outputs on the falling edge, advance the model, return #1 after the edge.
  task automatic step();
    logic exp_ready;
    logic load;
    @(negedge clk);
    exp_ready = !i_abort && !(m_count == 7 && m_valid && !i_ready);
    check("byte_ready", 64'(o_byte_ready), 64'(exp_ready));
    check("valid", 64'(o_valid), 64'(m_valid));
    check("count", 64'(o_count), 64'(m_count));
    check("roundtrip", des_fp({rev32(o_left), rev32(o_right)}), m_block);
    check("bypass_block", rev64({b_right, b_left}), m_block);
    last_acc = 1'b0;
    load     = 1'b0;
    if (i_rst) begin
      m_count = 0; m_asm = '0; m_valid = 1'b0; m_block = '0;
    end else begin
      if (i_abort) begin
        m_count = 0; m_asm = '0;
      end else if (i_byte_valid && exp_ready) begin
        last_acc = 1'b1;
        m_asm = {m_asm[55:0], i_byte};
        if (m_count == 7) begin
          m_block = m_asm; m_valid = 1'b1; load = 1'b1; m_count = 0; m_asm = '0;
        end else begin
          m_count++;
        end
      end
      if (m_valid && i_ready && !load) m_valid = 1'b0;
      if (i_ready && (load ? 1'b0 : 1'b1) && o_valid) drained++;
      else if (i_ready && load && o_valid) drained++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    i_byte = b;
    i_byte_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) check("send_timeout", 64'(0), 64'(1));
    i_byte_valid = 1'b0;
  endtask

  task automatic send_block(input logic [63:0] blk);
    for (int n = 0; n < 8; n++) send_byte(blk[63-8*n -: 8]);
  endtask

  initial begin
    logic [63:0] blk_a, blk_b, blk_c, blk_d, exp_ip;
    int cycles;

    ip_tab = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    fp_tab = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    kat[0] = '{64'h0123456789ABCDEF, 32'hCC00CCFF, 32'hF0AAF0AA};
    kat[1] = '{64'h0000000000000000, 32'h00000000, 32'h00000000};
    kat[2] = '{64'hFFFFFFFFFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    kat[3] = '{64'h8000000000000000, 32'h00000000, 32'h01000000};
    kat[4] = '{64'h0000000000000001, 32'h00000080, 32'h00000000};

    m_count = 0; m_asm = '0; m_valid = 1'b0; m_block = '0; last_acc = 1'b0; drained = 0;
    i_rst = 1'b1; i_byte = '0; i_byte_valid = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;
    step();

    // Known-answer table, bytes streamed back to back with the consumer always ready.
    i_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_block(kat[k].din);
      check("kat_valid", 64'(o_valid), 64'(1));
      check("kat_l0", 64'(rev32(o_left)), 64'(kat[k].l0));
      check("kat_r0", 64'(rev32(o_right)), 64'(kat[k].r0));
      check("kat_bypass", rev64({b_right, b_left}), kat[k].din);
      step();
      check("kat_one_cycle", 64'(o_valid), 64'(0));
    end

    // Back-pressure: 15 bytes go in, the 16th waits until the consumer drains.
    blk_a = 64'h1122334455667788;
    blk_b = 64'h99AABBCCDDEEFF00;
    i_ready = 1'b0;
    send_block(blk_a);
    for (int n = 0; n < 7; n++) send_byte(blk_b[63-8*n -: 8]);
    i_byte = blk_b[7:0];
    i_byte_valid = 1'b1;
    repeat (3) step();
    check("bp_count", 64'(o_count), 64'(7));
    check("bp_ready_low", 64'(o_byte_ready), 64'(0));
    exp_ip = des_ip(blk_a);
    check("bp_hold_l0", 64'(rev32(o_left)), 64'(exp_ip[63:32]));
    i_ready = 1'b1;
    #1;
    check("bp_ready_high", 64'(o_byte_ready), 64'(1));
    step();
    i_byte_valid = 1'b0;
    exp_ip = des_ip(blk_b);
    check("bp_second_valid", 64'(o_valid), 64'(1));
    check("bp_second_l0", 64'(rev32(o_left)), 64'(exp_ip[63:32]));
    check("bp_second_r0", 64'(rev32(o_right)), 64'(exp_ip[31:0]));
    step();

    // Abort after 5 bytes with a byte offered in the same cycle.
    blk_c = 64'hA5A55A5A0F0FF0F0;
    for (int n = 0; n < 5; n++) send_byte(8'hEE - 8'(n));
    i_abort = 1'b1; i_byte = 8'h3C; i_byte_valid = 1'b1;
    #1;
    check("abort_ready_low", 64'(o_byte_ready), 64'(0));
    step();
    i_abort = 1'b0; i_byte_valid = 1'b0;
    check("abort_count", 64'(o_count), 64'(0));
    send_block(blk_c);
    exp_ip = des_ip(blk_c);
    check("abort_next_l0", 64'(rev32(o_left)), 64'(exp_ip[63:32]));
    check("abort_next_r0", 64'(rev32(o_right)), 64'(exp_ip[31:0]));

    // Reset with a full slot and a partial block.
    blk_d = 64'hDEADBEEFCAFEF00D;
    step();
    send_block(blk_d);
    i_ready = 1'b0;
    for (int n = 0; n < 3; n++) send_byte(8'h10 + 8'(n));
    check("rst_pre_valid", 64'(o_valid), 64'(1));
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_count", 64'(o_count), 64'(0));
    check("rst_data", {o_left, o_right}, 64'(0));
    check("rst_ready", 64'(o_byte_ready), 64'(1));

    // Random round trip with valid/ready gaps.
    drained = 0;
    cycles  = 0;
    while (drained < 1000 && cycles < 60000) begin
      i_byte       = 8'($urandom);
      i_byte_valid = ($urandom_range(0, 3) != 0);
      i_ready      = ($urandom_range(0, 2) != 0);
      step();
      cycles++;
    end
    check("rand_blocks_done", 64'(drained >= 1000), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
